// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt pending arbiter.
package irq_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-input priority encoder; the highest set bit wins.
module prio_enc_n #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        // Ascending scan, so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Edge-latching pending register with a valid/ready handshake on the granted index.
// Optional IRQ_MASK_EN adds mask_i, which hides pending bits from selection only.
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N     = N_REQ,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
`ifdef IRQ_MASK_EN
    input  logic [N-1:0]     mask_i,
`endif
    input  logic             irq_ready_i,
    output logic             irq_valid_o,
    output logic [IDX_W-1:0] irq_idx_o,
    output logic [N-1:0]     pending_o,
    output logic             overflow_o
);

    arb_state_t       state_q;
    logic [N-1:0]     req_q;
    logic [N-1:0]     pending_q;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic             overflow_q;

    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     sel_vec;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    always_comb begin
        rise = req_i & ~req_q;
        clr  = '0;
        if (valid_q && irq_ready_i) begin
            clr[idx_q] = 1'b1;
        end
`ifdef IRQ_MASK_EN
        sel_vec = pending_q & ~mask_i;
`else
        sel_vec = pending_q;
`endif
    end

    prio_enc_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec (sel_vec),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_q     <= req_i;
            // A rise on the bit being cleared this cycle re-arms it (set wins).
            pending_q <= (pending_q & ~clr) | rise;
            if (|(rise & pending_q & ~clr)) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (enc_any) begin
                        idx_q   <= enc_idx;
                        valid_q <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (irq_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_valid_o = valid_q;
    assign irq_idx_o   = idx_q;
    assign pending_o   = pending_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_irq_pending_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_i;
    logic [7:0] mask_v;
    logic       irq_ready_i;
    logic       irq_valid_o;
    logic [2:0] irq_idx_o;
    logic [7:0] pending_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state
    int m_pend, m_req, m_idx;
    bit m_valid, m_ovf;

    always #5 clk = ~clk;

    irq_pending_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
`ifdef IRQ_MASK_EN
        .mask_i      (mask_v),
`endif
        .irq_ready_i (irq_ready_i),
        .irq_valid_o (irq_valid_o),
        .irq_idx_o   (irq_idx_o),
        .pending_o   (pending_o),
        .overflow_o  (overflow_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input int v);
        return $clog2(v + 1) - 1;
    endfunction

    task automatic model_edge(input int req, input bit rdy, input bit r, input int msk);
        int rise, clr, sel;
        if (r) begin
            m_pend = 0; m_req = 0; m_idx = 0; m_valid = 0; m_ovf = 0;
        end else begin
            rise = req & ~m_req & 255;
            clr  = (m_valid && rdy) ? (1 << m_idx) : 0;
            if ((rise & m_pend & ~clr) != 0) m_ovf = 1;
            if (!m_valid) begin
                sel = m_pend & ~msk & 255;
                if (sel != 0) begin
                    m_idx   = highest(sel);
                    m_valid = 1;
                end
            end else if (rdy) begin
                m_valid = 0;
            end
            m_pend = ((m_pend & ~clr) | rise) & 255;
            m_req  = req;
        end
    endtask

    // Apply inputs for one clock, advance the model, compare all outputs after the edge.
    task automatic step(input string tag, input logic [7:0] req, input logic rdy, input logic r);
        int msk;
        rst         = r;
        req_i       = req;
        irq_ready_i = rdy;
`ifdef IRQ_MASK_EN
        msk = int'(mask_v);
`else
        msk = 0;
`endif
        @(posedge clk);
        model_edge(int'(req), rdy, r, msk);
        #1;
        check_eq({tag, ".pend"},  32'(pending_o),   32'(m_pend));
        check_eq({tag, ".valid"}, 32'(irq_valid_o), 32'(m_valid));
        check_eq({tag, ".idx"},   32'(irq_idx_o),   32'(m_idx));
        check_eq({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
    endtask

    initial begin
        rst = 1'b1; req_i = '0; irq_ready_i = 1'b0; mask_v = '0;

        // Request held through reset is a rise on the first cycle afterwards.
        step("rst", 8'h01, 1'b1, 1'b1);
        check_eq("rst_zero", {pending_o, irq_valid_o, irq_idx_o, overflow_o}, '0);
        step("s1", 8'h01, 1'b1, 1'b0);
        check_eq("s1_pend", 32'(pending_o), 32'h01);
        step("s1", 8'h01, 1'b1, 1'b0);
        check_eq("s1_grant", {irq_valid_o, irq_idx_o}, {1'b1, 3'd0});
        step("s1", 8'h01, 1'b1, 1'b0);
        check_eq("s1_done", {pending_o, irq_valid_o}, '0);

        // Two simultaneous rises: 4 then 3 with an idle cycle between.
        step("s2", 8'h00, 1'b1, 1'b0);
        step("s2", 8'h18, 1'b1, 1'b0);
        step("s2", 8'h18, 1'b1, 1'b0);
        check_eq("s2_g4", {irq_valid_o, irq_idx_o}, {1'b1, 3'd4});
        step("s2", 8'h18, 1'b1, 1'b0);
        check_eq("s2_gap", 32'(irq_valid_o), 32'd0);
        step("s2", 8'h18, 1'b1, 1'b0);
        check_eq("s2_g3", {irq_valid_o, irq_idx_o}, {1'b1, 3'd3});
        step("s2", 8'h18, 1'b1, 1'b0);
        check_eq("s2_ovf", 32'(overflow_o), 32'd0);

        // No preemption by a higher request while granted.
        step("s3", 8'h00, 1'b0, 1'b0);
        step("s3", 8'h04, 1'b0, 1'b0);
        step("s3", 8'h04, 1'b0, 1'b0);
        step("s3", 8'h84, 1'b0, 1'b0);
        step("s3", 8'h84, 1'b0, 1'b0);
        check_eq("s3_hold", {irq_valid_o, irq_idx_o}, {1'b1, 3'd2});
        step("s3", 8'h84, 1'b1, 1'b0);
        step("s3", 8'h84, 1'b0, 1'b0);
        check_eq("s3_next", {irq_valid_o, irq_idx_o}, {1'b1, 3'd7});

        // Double pulse on a pending bit sets sticky overflow.
        step("s4", 8'h00, 1'b0, 1'b1);
        step("s4", 8'h20, 1'b0, 1'b0);
        step("s4", 8'h00, 1'b0, 1'b0);
        step("s4", 8'h20, 1'b0, 1'b0);
        check_eq("s4_ovf", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) step("s4", 8'h00, 1'b1, 1'b0);
        check_eq("s4_sticky", 32'(overflow_o), 32'd1);

        // Rise on the accept cycle: set wins, no overflow, regrant.
        step("s5", 8'h00, 1'b0, 1'b1);
        step("s5", 8'h40, 1'b0, 1'b0);
        step("s5", 8'h00, 1'b0, 1'b0);
        step("s5", 8'h40, 1'b1, 1'b0);
        check_eq("s5_pend6", 32'(pending_o[6]), 32'd1);
        check_eq("s5_ovf", 32'(overflow_o), 32'd0);
        step("s5", 8'h40, 1'b0, 1'b0);
        check_eq("s5_regrant", {irq_valid_o, irq_idx_o}, {1'b1, 3'd6});

        // Reset during a grant with all requests held.
        mask_v = 8'h80;
        step("s6", 8'hFF, 1'b0, 1'b1);
        step("s6", 8'hFF, 1'b0, 1'b0);
        step("s6", 8'hFF, 1'b0, 1'b0);
        check_eq("s6_valid", 32'(irq_valid_o), 32'd1);
        step("s6", 8'hFF, 1'b0, 1'b1);
        check_eq("s6_rst", {pending_o, irq_valid_o, irq_idx_o, overflow_o}, '0);
        step("s6", 8'hFF, 1'b0, 1'b0);
        check_eq("s6_pend", 32'(pending_o), 32'hFF);
        step("s6", 8'hFF, 1'b0, 1'b0);
`ifdef IRQ_MASK_EN
        check_eq("s6_idx", {irq_valid_o, irq_idx_o}, {1'b1, 3'd6});
`else
        check_eq("s6_idx", {irq_valid_o, irq_idx_o}, {1'b1, 3'd7});
`endif

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [7:0] rq;
            rq = 8'($urandom) & 8'($urandom);
            mask_v = 8'($urandom) & 8'($urandom);
            step("rnd", rq, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_pending_arbiter.md
Name: irq_pending_arbiter

Overview:
- Sequential front end that turns raw 8-bit request lines into a registered, handshaked stream of priority-encoded indices.
- Latches rising edges of the requests into a pending register and presents the highest-numbered pending bit as a 3-bit index with a valid flag.
- Clears the presented bit when the consumer accepts it.
- Sits directly upstream of the downstream consumer, such as an interrupt vector or mux select stage, and wraps the combinational priority-encode function in state and a valid/ready handshake.

Parameters:
- N, 8, number of request lines; must be ≥ 2.
- IDX_W, $clog2(N), width of the encoded index (3 at default).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset; one clock, sampled on posedge clk.
- req_i  input  N  raw request lines; level input, edge-detected internally.
- irq_ready_i  input  1  consumer ready; acceptance occurs when irq_valid_o && irq_ready_i at a posedge.
- irq_valid_o  output  1  registered; irq_idx_o is valid.
- irq_idx_o  output  IDX_W  registered index of the granted pending bit; the highest index has priority.
- pending_o  output  N  registered pending vector.
- overflow_o  output  1  sticky flag; an edge arrived on a bit that was already pending.

Behaviour:
- Reset: pending_o=0, irq_valid_o=0, irq_idx_o=0, overflow_o=0, edge register req_q=0, FSM=IDLE.
  - Because req_q is cleared, a req_i bit held high through reset is seen as a rising edge on the first cycle after reset.
- Edge detect: rise = req_i & ~req_q, evaluated each cycle; req_q <= req_i every posedge.
- Pending update at each posedge: pending <= (pending & ~clr) | rise.
  - clr is one-hot(irq_idx_o) on acceptance, otherwise 0.
  - If a rise and a clear hit the same bit in the same cycle, set wins: the bit stays pending and overflow is not flagged.
- Overflow: overflow_o <= 1 when (rise & pending & ~clr) != 0. Stays set until rst.
- FSM with two states:
  - IDLE: irq_valid_o=0. If the registered pending != 0 at a posedge, load irq_idx_o = highest set bit of pending, set irq_valid_o=1, go to GRANT. Otherwise stay in IDLE.
  - GRANT: irq_valid_o=1 and irq_idx_o held stable. New, higher-priority pending bits do NOT preempt. On valid&&ready at a posedge, clear pending[irq_idx_o], drop irq_valid_o, return to IDLE.
- Latency:
  - A req_i rise sampled at posedge T0 appears in pending_o after T0.
  - irq_valid_o rises after T1 if the FSM was in IDLE.
- Throughput: at most one grant per 2 cycles; there is a mandatory IDLE cycle between grants.
- irq_idx_o keeps its last value while irq_valid_o=0.
- Ready with no valid has no effect.
- Reset mid-GRANT: all state is cleared on that posedge, and the outstanding grant is dropped without acceptance.

Optional Feature:
- Macro: IRQ_MASK_EN.
- Defined:
  - Adds input port mask_i [N].
  - FSM selection uses pending & ~mask_i; a masked bit still latches into pending and still counts for overflow.
  - A grant already held in GRANT is unaffected by later mask changes.
  - If all pending bits are masked, the FSM stays in IDLE.
- Undefined: no mask_i port; selection uses pending directly.

Decomposition:
- Package irq_pkg holds:
  - localparam N_REQ = 8 and IDX_W = $clog2(N_REQ);
  - typedef logic [N_REQ-1:0] req_vec_t and logic [IDX_W-1:0] idx_t;
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- One sub-module, prio_enc_n: combinational, N-input highest-bit-wins encoder with outputs idx and any.
  - Instantiated once on the (masked) pending vector.
  - The FSM uses any as the "something pending" condition.

Test Plan:
- Reset, then req_i=8'b0000_0001 held, irq_ready_i=1:
  - pending_o=8'h01 one cycle later;
  - irq_valid_o=1 with irq_idx_o=3'd0 the next cycle;
  - accepted; pending_o=8'h00 and irq_valid_o=0 afterward.
- req_i 0 -> 8'b0001_1000 in one cycle, irq_ready_i=1:
  - grants irq_idx_o=4 then irq_idx_o=3, with one IDLE cycle between;
  - overflow_o stays 0.
- irq_ready_i=0; req_i rises bit 2; once GRANT holds idx=2, raise bit 7:
  - irq_idx_o stays 2 until ready=1;
  - after acceptance the next grant is idx=7.
- Pulse req_i bit 5 twice (0->1->0->1) before acceptance, irq_ready_i=0:
  - overflow_o=1 and stays 1 until rst.
- Pulse bit 6 on exactly the cycle its grant is accepted:
  - pending_o[6] remains 1, overflow_o=0, and a second grant of idx=6 follows.
- Assert rst while irq_valid_o=1 and req_i=8'hFF held:
  - all outputs 0 after the reset posedge;
  - with rst low, pending_o=8'hFF one cycle later, then irq_idx_o=7;
  - with IRQ_MASK_EN and mask_i=8'h80, the first grant is idx=6.
